// File: rtl/riscv_mc_pkg.sv
// Shared types and constants for the multi-cycle RISC-V control unit.
// States, opcode values, ALUop encodings and fault codes.
package riscv_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  localparam logic [1:0] ALUOP_LSJ = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_ILL   = 2'b01;
  localparam logic [1:0] FC_FETCH = 2'b10;
  localparam logic [1:0] FC_DATA  = 2'b11;

endpackage

// File: rtl/riscv_mc_decode.sv
// Combinational opcode decoder for the multi-cycle controller.
// Produces datapath selects and class flags; the FSM gates strobes.
module riscv_mc_decode
  import riscv_mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       alusrc_o,
  output logic       memtoreg_o,
  output logic [1:0] aluop_o,
  output logic       jal_o,
  output logic       jalr_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       illegal_o
);

  always_comb begin
    alusrc_o    = 1'b0;
    memtoreg_o  = 1'b0;
    aluop_o     = ALUOP_LSJ;
    jal_o       = 1'b0;
    jalr_o      = 1'b0;
    is_load_o   = 1'b0;
    is_store_o  = 1'b0;
    is_branch_o = 1'b0;
    illegal_o   = 1'b0;
    unique case (opcode_i)
      OP_R:    aluop_o = ALUOP_R;
      OP_I: begin
        aluop_o  = ALUOP_I;
        alusrc_o = 1'b1;
      end
      OP_LD: begin
        alusrc_o   = 1'b1;
        memtoreg_o = 1'b1;
        is_load_o  = 1'b1;
      end
      OP_ST: begin
        alusrc_o   = 1'b1;
        is_store_o = 1'b1;
      end
      OP_BR: begin
        aluop_o     = ALUOP_BR;
        is_branch_o = 1'b1;
      end
      OP_JAL:  jal_o = 1'b1;
      OP_JALR: begin
        jalr_o   = 1'b1;
        alusrc_o = 1'b1;
      end
      OP_HALT: ;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle control FSM with memory wait-state timeout and sticky halt/fault.
// Define RISCV_MC_PERF_EN to build the cycle / retired-instruction counters.
module riscv_mc_controller
  import riscv_mc_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int MEM_WAIT_MAX = 15,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        opcode,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              pc_we,
  output logic              ir_we,
  output logic              ALUSrc,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic              Jal,
  output logic              Jalr,
  output logic [1:0]        ALUop,
  output logic              Halt,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              busy,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_instret
);

  localparam int WCW = $clog2(MEM_WAIT_MAX + 1);

  if (DATA_W < 1 || MEM_WAIT_MAX < 1) begin : g_bad_param
    $error("riscv_mc_controller: illegal parameter value");
  end

  state_e           state_q;
  logic [6:0]       opcode_q;
  logic [WCW-1:0]   wait_q;
  logic [1:0]       fault_code_q;

  logic [6:0] dec_op;
  logic       d_alusrc, d_memtoreg, d_jal, d_jalr;
  logic       d_load, d_store, d_branch, d_illegal;
  logic [1:0] d_aluop;
  logic       tmo, dec_en;

  // In DECODE the live opcode is classified; afterwards the latched copy.
  assign dec_op = (state_q == S_DECODE) ? opcode : opcode_q;
  assign tmo    = (wait_q == WCW'(MEM_WAIT_MAX));

  riscv_mc_decode u_dec (
    .opcode_i    (dec_op),
    .alusrc_o    (d_alusrc),
    .memtoreg_o  (d_memtoreg),
    .aluop_o     (d_aluop),
    .jal_o       (d_jal),
    .jalr_o      (d_jalr),
    .is_load_o   (d_load),
    .is_store_o  (d_store),
    .is_branch_o (d_branch),
    .illegal_o   (d_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      opcode_q     <= '0;
      wait_q       <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      wait_q <= '0;
      unique case (state_q)
        S_FETCH: begin
          if (mem_ack) begin
            state_q <= S_DECODE;
          end else if (tmo) begin
            state_q      <= S_FAULT;
            fault_code_q <= FC_FETCH;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        S_DECODE: begin
          opcode_q <= opcode;
          if (d_illegal) begin
            state_q      <= S_FAULT;
            fault_code_q <= FC_ILL;
          end else if (opcode == OP_HALT) begin
            state_q <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (d_load || d_store)
            state_q <= S_MEM;
          else if (d_branch || d_jal || d_jalr)
            state_q <= S_FETCH;
          else
            state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ack) begin
            state_q <= d_load ? S_WB : S_FETCH;
          end else if (tmo) begin
            state_q      <= S_FAULT;
            fault_code_q <= FC_DATA;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= state_q;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    Halt       = 1'b0;
    fault      = 1'b0;
    busy       = 1'b0;
    dec_en     = 1'b0;
    fault_code = FC_NONE;
    if (!reset) begin
      fault_code = fault_code_q;
      unique case (state_q)
        S_FETCH: begin
          busy    = 1'b1;
          mem_req = 1'b1;
          ir_we   = mem_ack;
        end
        S_DECODE: busy = 1'b1;
        S_EXEC: begin
          busy     = 1'b1;
          dec_en   = 1'b1;
          Branch   = d_branch;
          RegWrite = d_jal | d_jalr;
          pc_we    = d_branch | d_jal | d_jalr;
        end
        S_MEM: begin
          busy     = 1'b1;
          dec_en   = 1'b1;
          mem_req  = 1'b1;
          MemRead  = d_load;
          MemWrite = d_store;
          mem_we   = d_store;
          pc_we    = d_store & mem_ack;
        end
        S_WB: begin
          busy     = 1'b1;
          dec_en   = 1'b1;
          RegWrite = 1'b1;
          pc_we    = 1'b1;
        end
        S_HALT:  Halt  = 1'b1;
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
    ALUSrc   = dec_en & d_alusrc;
    MemtoReg = dec_en & d_memtoreg;
    Jal      = dec_en & d_jal;
    Jalr     = dec_en & d_jalr;
    ALUop    = dec_en ? d_aluop : ALUOP_LSJ;
  end

`ifdef RISCV_MC_PERF_EN
  logic [PERF_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (busy)  cyc_q <= cyc_q + PERF_W'(1);
      if (pc_we) ret_q <= ret_q + PERF_W'(1);
    end
  end

  assign perf_cycles  = reset ? '0 : cyc_q;
  assign perf_instret = reset ? '0 : ret_q;
`else
  assign perf_cycles  = '0;
  assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Randomized scoreboard bench for riscv_mc_controller.
module tb_riscv_mc_controller;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;
  localparam int WMAX = 15;

  logic        clk, reset, mem_ack;
  logic [6:0]  opcode;
  logic        mem_req, mem_we, pc_we, ir_we;
  logic        ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic        Branch, Jal, Jalr, Halt, fault, busy;
  logic [1:0]  ALUop, fault_code;
  logic [31:0] perf_cycles, perf_instret;

  riscv_mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we), .ir_we(ir_we),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .Jal(Jal), .Jalr(Jalr), .ALUop(ALUop), .Halt(Halt),
    .fault(fault), .fault_code(fault_code), .busy(busy),
    .perf_cycles(perf_cycles), .perf_instret(perf_instret)
  );

  typedef struct packed {
    logic mem_req, mem_we, pc_we, ir_we, RegWrite, MemRead, MemWrite;
    logic Branch, Halt, fault, busy;
    logic [1:0] fault_code;
    logic ALUSrc, MemtoReg, Jal, Jalr;
    logic [1:0] ALUop;
  } ctl_t;

  typedef struct {
    ctl_t e;
    ctl_t m;
    logic [31:0] pc;
    logic [31:0] pi;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;
  ctl_t got;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cnt_cyc = 0;
  logic [31:0] cnt_ret = 0;
  int term = 0;
  logic [1:0] fcode = 2'b00;
  logic [6:0] ops[7] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic legal(input logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_LD || op == OP_ST ||
           op == OP_BR || op == OP_JAL || op == OP_JALR || op == OP_HALT;
  endfunction

  function automatic ctl_t dec(input logic [6:0] op);
    ctl_t c = '0;
    c.ALUSrc = op == OP_I || op == OP_LD || op == OP_ST || op == OP_JALR;
    c.Jal    = op == OP_JAL;
    c.Jalr   = op == OP_JALR;
    c.ALUop  = op == OP_R ? 2'b10 : op == OP_I ? 2'b11 :
               op == OP_BR ? 2'b01 : 2'b00;
    return c;
  endfunction

  // decoded fields are only meaningful from EXEC through WB
  function automatic ctl_t dmask();
    ctl_t m = '1;
    m.ALUSrc = 1'b0; m.MemtoReg = 1'b0;
    m.Jal = 1'b0; m.Jalr = 1'b0; m.ALUop = 2'b00;
    return m;
  endfunction

  function automatic ctl_t xmask();
    ctl_t m = '1;
    m.MemtoReg = 1'b0;
    return m;
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic step(input logic r, input logic [6:0] op, input logic ack,
                      input ctl_t e, input ctl_t m);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; opcode = op; mem_ack = ack;
    x.e = e; x.m = m;
`ifdef RISCV_MC_PERF_EN
    x.pc = r ? 32'd0 : cnt_cyc;
    x.pi = r ? 32'd0 : cnt_ret;
`else
    x.pc = 32'd0;
    x.pi = 32'd0;
`endif
    exp_q.push_back(x);
    if (r) begin
      cnt_cyc = 0; cnt_ret = 0;
    end else begin
      if (e.busy)  cnt_cyc = cnt_cyc + 1;
      if (e.pc_we) cnt_ret = cnt_ret + 1;
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1'b1, r7(), rb(), '0, '1);
    term = 0; fcode = 2'b00;
  endtask

  task automatic idle(input int n);
    ctl_t e;
    for (int k = 0; k < n; k++) begin
      e = '0;
      if (term == 1) e.Halt = 1'b1;
      else begin
        e.fault = 1'b1; e.fault_code = fcode;
      end
      step(1'b0, r7(), rb(), e, dmask());
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw,
                           input int dw, input int rst_at);
    ctl_t e;
    logic ack, ld, st, ctl;
    int i;
    ld  = op == OP_LD;
    st  = op == OP_ST;
    ctl = op == OP_BR || op == OP_JAL || op == OP_JALR;
    i = 0;
    while (1) begin
      ack = i == fw;
      e = '0; e.busy = 1'b1; e.mem_req = 1'b1; e.ir_we = ack;
      step(1'b0, r7(), ack, e, dmask());
      if (ack) break;
      if (i == WMAX) begin
        term = 2; fcode = 2'b10; return;
      end
      i++;
    end
    e = '0; e.busy = 1'b1;
    step(1'b0, op, rb(), e, dmask());
    if (!legal(op)) begin
      term = 2; fcode = 2'b01; return;
    end
    if (op == OP_HALT) begin
      term = 1; return;
    end
    e = dec(op); e.busy = 1'b1;
    if (op == OP_BR) e.Branch = 1'b1;
    if (op == OP_JAL || op == OP_JALR) e.RegWrite = 1'b1;
    e.pc_we = ctl;
    step(1'b0, r7(), rb(), e, xmask());
    if (ctl) return;
    if (ld || st) begin
      i = 0;
      while (1) begin
        ack = i == dw;
        if (i == rst_at) begin
          do_reset(1); return;
        end
        e = dec(op); e.busy = 1'b1; e.mem_req = 1'b1;
        e.MemRead = ld; e.MemWrite = st; e.mem_we = st;
        e.pc_we = st & ack;
        step(1'b0, r7(), ack, e, xmask());
        if (ack) break;
        if (i == WMAX) begin
          term = 2; fcode = 2'b11; return;
        end
        i++;
      end
      if (st) return;
    end
    e = dec(op); e.busy = 1'b1; e.RegWrite = 1'b1;
    e.pc_we = 1'b1; e.MemtoReg = ld;
    step(1'b0, r7(), rb(), e, '1);
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 9) == 0) return $urandom_range(13, 17);
    return $urandom_range(0, 3);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mx = exp_q.pop_front();
      got = {mem_req, mem_we, pc_we, ir_we, RegWrite, MemRead, MemWrite,
             Branch, Halt, fault, busy, fault_code,
             ALUSrc, MemtoReg, Jal, Jalr, ALUop};
      n_cmp++;
      if (((got ^ mx.e) & mx.m) !== '0 || perf_cycles !== mx.pc ||
          perf_instret !== mx.pi) begin
        n_bad++;
        $display("FAIL ctl t=%0t got=%h exp=%h mask=%h perf got=%0d/%0d exp=%0d/%0d",
                 $time, got, mx.e, mx.m, perf_cycles, perf_instret,
                 mx.pc, mx.pi);
      end
    end
  end

  initial begin
    logic [6:0] op;
    int k, fw, dw, ra;
    reset = 1'b1; mem_ack = 1'b0; opcode = '0;
    do_reset(2);
    run_instr(OP_R, 0, 0, -1);
    run_instr(OP_LD, 2, 3, -1);
    run_instr(7'b0000000, 0, 0, -1); idle(4); do_reset(1);
    run_instr(OP_R, 16, 0, -1); idle(3); do_reset(1);
    run_instr(OP_R, 15, 0, -1);
    run_instr(OP_ST, 0, 16, -1); idle(3); do_reset(1);
    run_instr(OP_LD, 0, 15, -1);
    run_instr(OP_HALT, 0, 0, -1); idle(4); do_reset(1);
    run_instr(OP_I, 0, 0, -1);
    run_instr(OP_ST, 1, 4, 2);
    run_instr(OP_ST, 0, 0, -1);
    run_instr(OP_BR, 0, 0, -1);
    run_instr(OP_JAL, 0, 0, -1);
    run_instr(OP_JALR, 1, 0, -1);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 99);
      if (k < 3) begin
        op = r7();
        while (legal(op)) op = r7();
      end else if (k < 5) begin
        op = OP_HALT;
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      fw = pick_wait();
      dw = pick_wait();
      ra = -1;
      if ($urandom_range(0, 19) == 0)
        ra = $urandom_range(0, dw > WMAX ? WMAX : dw);
      run_instr(op, fw, dw, ra);
      if (term != 0) begin
        idle(2);
        do_reset($urandom_range(1, 2));
      end
    end
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
